if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have imem_req_addr  output  PC_WIDTH  fetch address.
REQ-008 SHALL have imem_resp_valid  input  1  instruction word returned, in request order, latency >= 1 cycle.
REQ-009 SHALL have imem_resp_data  input  32  instruction word.
REQ-010 SHALL have redirect_valid  input  1  branch/jump redirect.
REQ-011 SHALL have redirect_pc  input  PC_WIDTH  redirect target.
REQ-012 SHALL have id_stall  input  1  downstream IF/ID register holds.
REQ-013 SHALL have if_valid  output  1  if_pc/if_inst hold a valid fetched instruction.
REQ-014 SHALL have if_pc  output  PC_WIDTH  PC of presented instruction.
REQ-015 SHALL have if_inst  output  32  presented instruction word.

Function
REQ-016 SHALL keep a fetch PC register; a request is accepted when imem_req_valid && imem_req_ready, and the PC then advances by 4, wrapping modulo 2^PC_WIDTH.
REQ-017 SHALL drive imem_req_addr = fetch PC, with bits [1:0] always 0.
REQ-018 SHALL assert imem_req_valid only in state RUN and only when outstanding + fifo_count < 2.
REQ-019 SHALL hold imem_req_addr stable while imem_req_valid && !imem_req_ready, except that a redirect may withdraw the request.
REQ-020 SHALL track outstanding requests in a 0..2 counter: +1 on acceptance, -1 on response, net 0 when both occur in the same cycle.
REQ-021 SHALL write each non-discarded response {pc, inst} into a 2-entry FIFO, so if_valid rises the cycle after imem_resp_valid.
REQ-022 SHALL present the FIFO head on if_pc/if_inst and pop it when if_valid && !id_stall; a push and a pop in the same cycle SHALL both take effect.
REQ-023 SHALL drive if_pc = 0 and if_inst = 32'h0000_0013 (NOP) whenever if_valid = 0.
REQ-024 SHALL implement states RUN and DRAIN: RUN -> DRAIN on redirect_valid when outstanding (after this cycle's acceptance) > 0; RUN -> RUN on redirect with none outstanding; DRAIN -> RUN when outstanding reaches 0.
REQ-025 SHALL, on redirect_valid, flush the FIFO, load fetch PC with {redirect_pc[PC_WIDTH-1:2],2'b00}, and deassert if_valid the next cycle.
REQ-026 SHALL discard every response arriving in DRAIN or in the same cycle as redirect_valid, and SHALL count any request accepted in the redirect cycle as outstanding-to-discard.
REQ-027 SHALL give redirect priority over id_stall, pop, push, and PC increment.
REQ-028 SHALL accept a redirect in DRAIN by updating fetch PC and remaining in DRAIN.
REQ-029 SHALL ignore imem_resp_valid when outstanding = 0 (protocol error; no state change).

Reset
REQ-030 SHALL, on rst, set fetch PC = RESET_PC, state = RUN, outstanding = 0, FIFO empty, if_valid = 0, if_pc = 0, if_inst = NOP.
REQ-031 SHALL drive imem_req_valid = 0 during rst and MAY assert it in the first cycle after rst deasserts.
REQ-032 SHALL abandon in-flight requests at reset mid-operation; the memory side is reset by the same rst.

Structure
REQ-033 SHALL take PC_WIDTH from the shared defines_bitwidth.vh header and the NOP encoding from a shared instruction-constant header.
REQ-034 SHALL implement the 2-entry {pc, inst} buffer as sub-module fetch_fifo with push, pop, flush, full, empty, and count.

Verification
REQ-035 SHALL cover reset: RESET_PC = 0x100, ready = 1, 1-cycle response latency -> requests 0x100, 0x104, 0x108; if_pc sequence 0x100, 0x104, 0x108 with matching data, and first if_valid 2 cycles after rst deasserts.
REQ-036 SHALL cover backpressure: id_stall high for 5 cycles -> FIFO fills to 2, imem_req_valid = 0, if_pc held; on release, in-order delivery with no loss or duplication.
REQ-037 SHALL cover redirect with 2 outstanding: redirect_pc = 0x2002 -> both old responses discarded, DRAIN until outstanding = 0, next request address 0x2000, first if_pc after redirect 0x2000.
REQ-038 SHALL cover simultaneous events: redirect, response, and acceptance in one cycle -> response dropped, accepted request later dropped, FIFO empty next cycle.
REQ-039 SHALL cover wrap: PC_WIDTH = 32, redirect to 0xFFFF_FFFC -> next request addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-040 SHALL cover ready low: imem_req_ready = 0 for 3 cycles -> imem_req_addr stable and PC not advanced.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage and its response buffer.
package if_stage_pkg;

  localparam int unsigned PC_WIDTH_DEF = 32;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned SUM_W        = CNT_W + 1;
  localparam int unsigned MAX_INFLIGHT = 2;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // Fetch may issue only while requests in flight plus buffered words leave a free slot.
  function automatic logic slot_free(input logic [CNT_W-1:0] outst,
                                     input logic [CNT_W-1:0] count);
    return (SUM_W'(outst) + SUM_W'(count)) < SUM_W'(MAX_INFLIGHT);
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Two-entry {pc, inst} buffer between the instruction memory and the IF/ID register.
module fetch_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic [INST_W-1:0]   push_inst,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count,
  output logic [PC_WIDTH-1:0] head_pc,
  output logic [INST_W-1:0]   head_inst
);

  logic [PC_WIDTH-1:0] pc_q   [2];
  logic [PC_WIDTH-1:0] pc_d   [2];
  logic [INST_W-1:0]   inst_q [2];
  logic [INST_W-1:0]   inst_d [2];
  logic                head_q, head_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pop_ok, push_ok, wr_idx;

  // A push into a full buffer is allowed only when the head leaves in the same cycle.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    head_d  = head_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != CNT_W'(2)) || pop_ok);
    wr_idx  = head_q ^ count_q[0];
    if (flush) begin
      head_d  = 1'b0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        pc_d[wr_idx]   = push_pc;
        inst_d[wr_idx] = push_inst;
      end
      if (pop_ok) head_d = ~head_q;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= 1'b0;
      count_q   <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      inst_q[0] <= INST_NOP;
      inst_q[1] <= INST_NOP;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign full      = (count_q == CNT_W'(2));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_pc   = pc_q[head_q];
  assign head_inst = inst_q[head_q];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential fetches, buffers returned words, and
// drains stale responses after a redirect before resuming at the new target.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_W-1:0]   imem_resp_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                id_stall,
  output logic                if_valid,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [INST_W-1:0]   if_inst
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    outst_q, outst_d;

  logic                req_valid, accept, resp_take, discard, push, pop;
  logic [PC_WIDTH-1:0] resp_pc;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [PC_WIDTH-1:0] head_pc;
  logic [INST_W-1:0]   head_inst;

  fetch_fifo #(.PC_WIDTH(PC_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (resp_pc),
    .push_inst (imem_resp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  // Live requests are consecutive since the last redirect, so the oldest one's PC
  // sits outst_q words behind the fetch PC.
  always_comb begin
    req_valid = !rst && (state_q == ST_RUN) && slot_free(outst_q, fifo_count);
    accept    = req_valid && imem_req_ready;
    resp_take = imem_resp_valid && (outst_q != '0);
    discard   = redirect_valid || (state_q == ST_DRAIN);
    resp_pc   = pc_q - (PC_WIDTH'(outst_q) << 2);
    pop       = !fifo_empty && !id_stall && !redirect_valid;
    push      = resp_take && !discard && (!fifo_full || pop);
    outst_d   = outst_q + CNT_W'(accept) - CNT_W'(resp_take);
    pc_d      = pc_q;
    state_d   = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      state_d = (outst_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (accept) pc_d = pc_q + PC_STEP;
      if ((state_q == ST_DRAIN) && (outst_d == '0)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC & ALIGN_MASK;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign if_valid       = !fifo_empty;
  assign if_pc          = fifo_empty ? '0 : head_pc;
  assign if_inst        = fifo_empty ? INST_NOP : head_inst;

endmodule

// File: tb/tb_if_stage.sv
// Cycle-table bench for if_stage with a small in-order memory model (data = ~addr).
module tb_if_stage;

  localparam int unsigned PW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [PW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          id_stall;
  logic          if_valid;
  logic [PW-1:0] if_pc;
  logic [31:0]   if_inst;

  if_stage #(.PC_WIDTH(PW), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_stall        (id_stall),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        hold;
    logic        spur;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rp,
                     input logic rdy, input logic hd, input logic sp,
                     input logic rv, input logic [31:0] ad,
                     input logic iv, input logic [31:0] pc);
    vec_t r;
    r.stall = st; r.redir = rd; r.rpc = rp; r.ready = rdy; r.hold = hd; r.spur = sp;
    r.exp_rv = rv; r.exp_addr = ad; r.exp_iv = iv; r.exp_pc = pc;
    vecs.push_back(r);
  endtask

  // Drive one cycle from a negedge, check outputs, update the memory model at posedge.
  task automatic run_cycle(input vec_t r, input string tag);
    logic        acc, popped;
    logic [31:0] addr, exp_inst;
    id_stall       = r.stall;
    redirect_valid = r.redir;
    redirect_pc    = r.rpc;
    imem_req_ready = r.ready;
    popped         = !r.hold && (mq.size() > 0);
    if (popped) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~mq[0];
    end else if (r.spur) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    exp_inst = r.exp_iv ? ~r.exp_pc : NOP;
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(r.exp_rv));
    chk({tag, " req_addr"},  imem_req_addr, r.exp_addr);
    chk({tag, " if_valid"},  32'(if_valid), 32'(r.exp_iv));
    chk({tag, " if_pc"},     if_pc, r.exp_iv ? r.exp_pc : 32'h0);
    chk({tag, " if_inst"},   if_inst, exp_inst);
    acc  = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    @(posedge clk);
    if (popped) void'(mq.pop_front());
    if (acc) mq.push_back(addr);
    @(negedge clk);
  endtask

  initial begin
    vec_t r;
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;

    // Streaming from reset: 2/3 throughput with 1-cycle latency.
    add(0,0,0,1,0,0, 1,32'h100,0,0);
    add(0,0,0,1,0,0, 1,32'h104,0,0);
    add(0,0,0,1,0,0, 0,32'h108,1,32'h100);
    add(0,0,0,1,0,0, 1,32'h108,1,32'h104);
    add(0,0,0,1,0,0, 1,32'h10c,0,0);
    add(0,0,0,1,0,0, 0,32'h110,1,32'h108);
    add(0,0,0,1,0,0, 1,32'h110,1,32'h10c);
    // id_stall for 5 cycles: buffer fills, requests stop, head held.
    add(1,0,0,1,0,0, 1,32'h114,0,0);
    add(1,0,0,1,0,0, 0,32'h118,1,32'h110);
    add(1,0,0,1,0,0, 0,32'h118,1,32'h110);
    add(1,0,0,1,0,0, 0,32'h118,1,32'h110);
    add(1,0,0,1,0,0, 0,32'h118,1,32'h110);
    add(0,0,0,1,0,0, 0,32'h118,1,32'h110);
    add(0,0,0,1,0,0, 1,32'h118,1,32'h114);
    add(0,0,0,1,0,0, 1,32'h11c,0,0);
    add(0,0,0,1,0,0, 0,32'h120,1,32'h118);
    // Two requests held in memory, then redirect to 0x2002.
    add(0,0,0,1,1,0, 1,32'h120,1,32'h11c);
    add(0,0,0,1,1,0, 1,32'h124,0,0);
    add(0,1,32'h2002,1,1,0, 0,32'h128,0,0);
    add(0,0,0,1,0,0, 0,32'h2000,0,0);
    add(0,0,0,1,0,0, 0,32'h2000,0,0);
    add(0,0,0,1,0,0, 1,32'h2000,0,0);
    add(0,0,0,1,0,0, 1,32'h2004,0,0);
    add(0,0,0,1,0,0, 0,32'h2008,1,32'h2000);
    add(0,0,0,1,0,0, 1,32'h2008,1,32'h2004);
    // Redirect coinciding with a response and an acceptance.
    add(0,1,32'h3000,1,0,0, 1,32'h200c,0,0);
    add(0,0,0,1,0,0, 0,32'h3000,0,0);
    add(0,0,0,1,0,0, 1,32'h3000,0,0);
    add(0,0,0,1,0,0, 1,32'h3004,0,0);
    add(0,0,0,1,0,0, 0,32'h3008,1,32'h3000);
    // Redirect to the top of the address space: fetch wraps to zero.
    add(0,1,32'hFFFF_FFFC,1,0,0, 1,32'h3008,1,32'h3004);
    add(0,0,0,1,0,0, 0,32'hFFFF_FFFC,0,0);
    add(0,0,0,1,0,0, 1,32'hFFFF_FFFC,0,0);
    add(0,0,0,1,0,0, 1,32'h0,0,0);
    add(0,0,0,1,0,0, 0,32'h4,1,32'hFFFF_FFFC);
    // Memory not ready for 3 cycles: address held, PC frozen.
    add(0,0,0,0,0,0, 1,32'h4,1,32'h0);
    add(0,0,0,0,0,0, 1,32'h4,0,0);
    add(0,0,0,0,0,0, 1,32'h4,0,0);
    add(0,0,0,1,0,0, 1,32'h4,0,0);
    add(0,0,0,1,0,0, 1,32'h8,0,0);
    add(0,0,0,1,0,0, 0,32'hc,1,32'h4);
    // Spurious response with nothing outstanding is ignored.
    add(0,0,0,0,0,0, 1,32'hc,1,32'h8);
    add(0,0,0,0,0,1, 1,32'hc,0,0);
    add(0,0,0,0,0,0, 1,32'hc,0,0);
    add(0,0,0,1,0,0, 1,32'hc,0,0);
    add(0,0,0,1,0,0, 1,32'h10,0,0);
    add(0,0,0,1,0,0, 0,32'h14,1,32'hc);

    repeat (2) @(negedge clk);
    chk("reset req_valid", 32'(imem_req_valid), 32'h0);
    chk("reset if_valid",  32'(if_valid), 32'h0);
    chk("reset if_pc",     if_pc, 32'h0);
    chk("reset if_inst",   if_inst, NOP);
    rst = 1'b0;
    foreach (vecs[i]) run_cycle(vecs[i], $sformatf("c%0d", i));

    // Reset mid-operation abandons in-flight work and restarts at RESET_PC.
    rst = 1'b1; imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; id_stall = 1'b0;
    #1;
    chk("midrst req_valid", 32'(imem_req_valid), 32'h0);
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    r = '{stall:0, redir:0, rpc:0, ready:1, hold:0, spur:0,
          exp_rv:1, exp_addr:32'h100, exp_iv:0, exp_pc:0};
    run_cycle(r, "rr0");
    r.exp_addr = 32'h104;
    run_cycle(r, "rr1");
    r.exp_rv = 0; r.exp_addr = 32'h108; r.exp_iv = 1; r.exp_pc = 32'h100;
    run_cycle(r, "rr2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
